// File: rtl/prng_pkg.sv
// Shared types and default geometry for the PRNG buffer controller.
package prng_pkg;

  localparam int PRNG_AW    = 6;
  localparam int PRNG_DW    = 12;
  localparam int PRNG_DEPTH = 64;
  localparam int CNT_W      = PRNG_AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/prng_buf_ctrl_if.sv
// Generator, consumer and RAM-side signals of the PRNG buffer controller.
interface prng_buf_ctrl_if
  import prng_pkg::*;
#(
  parameter int AW = PRNG_AW,
  parameter int DW = PRNG_DW
);

  logic          gen_valid;
  logic [DW-1:0] gen_data;
  logic          gen_ready;
  logic          ram_en;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  // master is the controller; slave is the generator/RAM/consumer side
  modport master (
    input  gen_valid, gen_data, ram_r_data, out_ready,
    output gen_ready, ram_en, ram_w_addr, ram_w_data, ram_r_addr,
           out_valid, out_data
  );

  modport slave (
    output gen_valid, gen_data, ram_r_data, out_ready,
    input  gen_ready, ram_en, ram_w_addr, ram_w_data, ram_r_addr,
           out_valid, out_data
  );

endinterface

// File: rtl/buf_occupancy.sv
// Circular-buffer write/read pointers and occupancy count with full/empty flags.
module buf_occupancy
  import prng_pkg::*;
#(
  parameter int AW    = PRNG_AW,
  parameter int DEPTH = PRNG_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic          rd,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/prng_buf_ctrl.sv
// Sequences the PRNG RAM as a circular buffer: pre-fill, stream, drain.
module prng_buf_ctrl
  import prng_pkg::*;
#(
  parameter int AW       = PRNG_AW,
  parameter int DW       = PRNG_DW,
  parameter int DEPTH    = PRNG_DEPTH,
  parameter int FILL_LVL = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  prng_buf_ctrl_if.master       bus,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            state
);

  state_t        cur_state, nxt_state;
  logic          gen_ready, out_valid, wr, rd;
  logic          fill_hit, drain_done;
  logic [AW-1:0] wr_ptr, rd_ptr;

  buf_occupancy #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_occ (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (wr),
    .rd     (rd),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    gen_ready  = 1'b0;
    out_valid  = 1'b0;
    wr         = 1'b0;
    rd         = 1'b0;
    fill_hit   = 1'b0;
    drain_done = 1'b0;
    nxt_state  = cur_state;

    gen_ready = ((cur_state == FILL) || (cur_state == STREAM)) && !full;
    out_valid = ((cur_state == STREAM) || (cur_state == DRAIN)) && !empty;
    wr        = bus.gen_valid && gen_ready;
    rd        = out_valid && bus.out_ready;
    // threshold and drain-exit both look at the post-edge occupancy
    fill_hit   = (int'(count) + int'(wr)) >= FILL_LVL;
    drain_done = (count == {{AW{1'b0}}, rd});

    case (cur_state)
      IDLE:    if (start && !stop) nxt_state = FILL;
      FILL:    if (stop) nxt_state = DRAIN;
               else if (fill_hit) nxt_state = STREAM;
      STREAM:  if (stop) nxt_state = DRAIN;
      DRAIN:   if (drain_done) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign bus.gen_ready  = gen_ready;
  assign bus.ram_en     = wr;
  assign bus.ram_w_addr = wr_ptr;
  assign bus.ram_w_data = bus.gen_data;
  assign bus.ram_r_addr = rd_ptr;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = bus.ram_r_data;
  assign state          = cur_state;

endmodule
